game_sequencer: RTL
===================

# game_sequencer

Frame-synchronous game controller for the sprite render path: owns the game state, lives, score and fruit position that the sprite printers consume. Collision events raised during scan-out are latched and applied once per frame at a fixed blanking line. All sprite reconfiguration therefore happens outside the visible area. It drives `stateGame` to the pixel mux, heart enables to the three heart printers, and `new_position_x/y` plus `moveSprite` to the fruit printer.

## Interface
Parameters:
- `FRAME_LINE`, 601: `pixel_y` value that marks the per-frame update point, inside vertical blanking.
- `FIELD_X0`, 100: minimum fruit x.
- `FIELD_Y0`, 100: minimum fruit y.
- `FRUIT_X_INIT`, 400: fruit x after reset or game start.
- `FRUIT_Y_INIT`, 400: fruit y after reset or game start.
- `PAUSE_FRAMES`, 60: frames spent in HIT after losing a life.
- `LFSR_SEED`, 16'hACE1: nonzero LFSR reset value.

Ports:
- `clk` in 1: pixel clock; `pixel_x` advances once per cycle.
- `reset` in 1: asynchronous, active-high.
- `pixel_x` in 11: current scan column.
- `pixel_y` in 10: current scan line.
- `start` in 1: start button, level; rising-edge detected internally.
- `hit_fruit` in 1: head/fruit overlap pulse.
- `hit_wall` in 1: head/barrier or self overlap pulse.
- `stateGame` out 3: 000 IDLE, 001 PLAY, 010 HIT, 011 OVER.
- `lives` out 2: remaining lives, 0..3.
- `heart_en` out 3: thermometer of `lives` (3→111, 2→011, 1→001, 0→000).
- `score` out 8: fruits eaten, saturating.
- `fruit_x` out 11: fruit position x.
- `fruit_y` out 10: fruit position y.
- `fruit_move` out 1: one-cycle load strobe for the fruit printer.

## Operation
- Frame tick `tick` = (`pixel_x`==0 && `pixel_y`==FRAME_LINE); combinational, one cycle per frame.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every cycle in every state.
- Pending flags `pf` and `pw`:
  - Set by `hit_fruit` / `hit_wall` only while in PLAY.
  - Cleared on `tick`.
  - An event coinciding with `tick` is kept pending for the next frame: set has priority over clear on that cycle.
- IDLE:
  - A `start` rising edge causes: lives←3, score←0, fruit←(FRUIT_X_INIT, FRUIT_Y_INIT), `fruit_move` pulse, →PLAY.
  - Takes effect immediately; does not wait for `tick`.
- PLAY, on `tick`:
  - If `pf`: score←min(score+1, 255); fruit_x←FIELD_X0+lfsr[8:0]; fruit_y←FIELD_Y0+lfsr[15:8]; `fruit_move` pulse.
  - If `pw`: lives←lives−1. If the result is 0, →OVER; else load pause counter with PAUSE_FRAMES and →HIT.
  - `pf` and `pw` on the same tick: both are applied, fruit update included.
- HIT: pause counter decrements on each `tick`. At 0 it goes →PLAY on that tick. Wall and fruit events are ignored.
- OVER: score and hearts are frozen. A `start` rising edge →IDLE.
- Arithmetic:
  - Fruit coordinates are zero-extended unsigned adds, no clamping; maximum x = FIELD_X0+511, maximum y = FIELD_Y0+255.
  - lives never decrements below 0.
- Reset mid-frame or mid-pause: everything clears asynchronously. Pending events are discarded.

## Timing
- All outputs are registered on posedge `clk`.
- Reset values: `stateGame`=000, `lives`=3, `heart_en`=111, `score`=0, `fruit_x`=FRUIT_X_INIT, `fruit_y`=FRUIT_Y_INIT, `fruit_move`=0. Pending flags=0, pause counter=0, LFSR=LFSR_SEED.
- `tick` sampled at edge T: updated `stateGame`, `lives`, `score` and fruit position are visible after edge T; `fruit_move` is high for exactly the cycle following edge T.
- `fruit_x`/`fruit_y` are stable in the cycle `fruit_move` is high and held until the next update.
- `start` edge at edge T: state changes after edge T+1, allowing one cycle for the edge-detect register.
- `heart_en` changes in the same cycle as `lives`.

## Configuration
- `GAME_INVULN_EN` defined: HIT state and pause counter are present, as described above.
- Undefined: no pause counter; a nonfatal wall hit stays in PLAY. `stateGame` never takes the value 010. A wall event during the following frame is processed normally on the next tick.

## Test plan
- Reset, then `start` pulse → `stateGame`=001, `lives`=3, `heart_en`=111, `score`=0, fruit=(400,400), one `fruit_move` pulse.
- `hit_fruit` mid-frame in PLAY → nothing changes until `pixel_y`=601/`pixel_x`=0; next cycle score=1, `fruit_move`=1, fruit_x within 100..611, fruit_y within 100..355.
- Three `hit_wall` events in separate frames:
  - With `GAME_INVULN_EN`: lives 3→2→1→0, 010 entered for 60 ticks between hits, final `stateGame`=011, `heart_en`=000.
  - Without `GAME_INVULN_EN`: no 010 observed.
- `hit_wall` asserted on the tick cycle → ignored that tick, applied on the next tick (lives decrements one frame later).
- 256 fruit events → score saturates at 255; `hit_fruit`+`hit_wall` on the same frame → score+1 and lives−1 on the same tick.
- Assert `reset` during HIT → immediate return to `stateGame`=000, lives=3, no `fruit_move` pulse after release.

Source files
------------

// File: rtl/game_sequencer.sv
// Frame-synchronous game controller: state, lives, score and fruit placement.
// Optional post-hit pause (HIT state) is built when GAME_INVULN_EN is defined.
module game_sequencer #(
    parameter int          FRAME_LINE   = 601,
    parameter int          FIELD_X0     = 100,
    parameter int          FIELD_Y0     = 100,
    parameter int          FRUIT_X_INIT = 400,
    parameter int          FRUIT_Y_INIT = 400,
    parameter int          PAUSE_FRAMES = 60,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        start,
    input  logic        hit_fruit,
    input  logic        hit_wall,
    output logic [2:0]  stateGame,
    output logic [1:0]  lives,
    output logic [2:0]  heart_en,
    output logic [7:0]  score,
    output logic [10:0] fruit_x,
    output logic [9:0]  fruit_y,
    output logic        fruit_move
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_PLAY = 3'b001,
        S_HIT  = 3'b010,
        S_OVER = 3'b011
    } state_t;

    state_t      state_q;
    logic [1:0]  lives_q;
    logic [2:0]  heart_en_q;
    logic [7:0]  score_q;
    logic [10:0] fruit_x_q;
    logic [9:0]  fruit_y_q;
    logic        fruit_move_q;

    logic [15:0] lfsr_q, lfsr_d;
    logic        start_q, start_qq;
    logic        pf_q, pf_d;
    logic        pw_q, pw_d;
`ifdef GAME_INVULN_EN
    logic [15:0] pause_q;
`endif

    logic        tick;
    logic        start_rise;
    logic        in_play;
    logic [7:0]  score_inc;
    logic [1:0]  lives_dec;
    logic [10:0] fruit_x_new;
    logic [9:0]  fruit_y_new;

    function automatic logic [2:0] thermo(input logic [1:0] l);
        case (l)
            2'd3:    thermo = 3'b111;
            2'd2:    thermo = 3'b011;
            2'd1:    thermo = 3'b001;
            default: thermo = 3'b000;
        endcase
    endfunction

    assign tick       = (pixel_x == 11'd0) && (pixel_y == FRAME_LINE[9:0]);
    assign start_rise = start_q & ~start_qq;
    assign in_play    = (state_q == S_PLAY);

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                     lfsr_q[15:1]};

    // A hit on the tick cycle survives the clear and lands next frame
    assign pf_d = (in_play & hit_fruit) | (pf_q & ~tick);
    assign pw_d = (in_play & hit_wall)  | (pw_q & ~tick);

    assign score_inc   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    assign lives_dec   = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
    assign fruit_x_new = FIELD_X0[10:0] + {2'b00, lfsr_q[8:0]};
    assign fruit_y_new = FIELD_Y0[9:0] + {2'b00, lfsr_q[15:8]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q   <= LFSR_SEED;
            start_q  <= 1'b0;
            start_qq <= 1'b0;
            pf_q     <= 1'b0;
            pw_q     <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            start_q  <= start;
            start_qq <= start_q;
            pf_q     <= pf_d;
            pw_q     <= pw_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lives_q      <= 2'd3;
            heart_en_q   <= 3'b111;
            score_q      <= 8'd0;
            fruit_x_q    <= FRUIT_X_INIT[10:0];
            fruit_y_q    <= FRUIT_Y_INIT[9:0];
            fruit_move_q <= 1'b0;
`ifdef GAME_INVULN_EN
            pause_q      <= 16'd0;
`endif
        end else begin
            fruit_move_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_rise) begin
                        lives_q      <= 2'd3;
                        heart_en_q   <= 3'b111;
                        score_q      <= 8'd0;
                        fruit_x_q    <= FRUIT_X_INIT[10:0];
                        fruit_y_q    <= FRUIT_Y_INIT[9:0];
                        fruit_move_q <= 1'b1;
                        state_q      <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        if (pf_q) begin
                            score_q      <= score_inc;
                            fruit_x_q    <= fruit_x_new;
                            fruit_y_q    <= fruit_y_new;
                            fruit_move_q <= 1'b1;
                        end
                        if (pw_q) begin
                            lives_q    <= lives_dec;
                            heart_en_q <= thermo(lives_dec);
                            if (lives_dec == 2'd0) begin
                                state_q <= S_OVER;
                            end else begin
`ifdef GAME_INVULN_EN
                                pause_q <= PAUSE_FRAMES[15:0];
                                state_q <= S_HIT;
`endif
                            end
                        end
                    end
                end
`ifdef GAME_INVULN_EN
                S_HIT: begin
                    if (tick) begin
                        if (pause_q <= 16'd1) begin
                            pause_q <= 16'd0;
                            state_q <= S_PLAY;
                        end else begin
                            pause_q <= pause_q - 16'd1;
                        end
                    end
                end
`endif
                S_OVER: begin
                    if (start_rise) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stateGame  = state_q;
    assign lives      = lives_q;
    assign heart_en   = heart_en_q;
    assign score      = score_q;
    assign fruit_x    = fruit_x_q;
    assign fruit_y    = fruit_y_q;
    assign fruit_move = fruit_move_q;

endmodule
